// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among instruction fetchers.
// Optional one-entry bypass buffer enabled by defining FETCH_ARBITER_BYPASS_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request in flight; pick next fetcher round-robin
// REQUEST | memory request outstanding, waiting for mem_read_ready
// RELAY   | ready pulse being returned to the granted fetcher
module fetch_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    RELAY   = 2'b10
  } state_t;

  state_t                             state_q, state_d;
  logic [GW-1:0]                      grant_q, grant_d;
  logic [GW-1:0]                      last_grant_q, last_grant_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q, consumer_read_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

`ifdef FETCH_ARBITER_BYPASS_EN
  logic                 buf_valid_q, buf_valid_d;
  logic [ADDR_BITS-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
`endif

  logic [GW-1:0]        pick;
  logic                 pick_found;
  logic [ADDR_BITS-1:0] pick_addr;

  // First requester after last_grant, wrapping; works for non-power-of-two counts.
  always_comb begin : rr_pick
    int cand;
    cand       = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int off = 1; off <= NUM_CONSUMERS; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
      if (!pick_found && |(consumer_read_valid & (NUM_CONSUMERS'(1) << cand))) begin
        pick_found = 1'b1;
        pick       = GW'(cand);
      end
    end
  end

  assign pick_addr = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    last_grant_d         = last_grant_q;
    mem_read_valid_d     = mem_read_valid_q;
    mem_read_address_d   = mem_read_address_q;
    consumer_read_ready_d = '0;
    consumer_read_data_d = consumer_read_data_q;
`ifdef FETCH_ARBITER_BYPASS_EN
    buf_valid_d          = buf_valid_q;
    buf_addr_d           = buf_addr_q;
    buf_data_d           = buf_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick;
          last_grant_d = pick;
`ifdef FETCH_ARBITER_BYPASS_EN
          if (buf_valid_q && (pick_addr == buf_addr_q)) begin
            consumer_read_data_d[pick*DATA_BITS +: DATA_BITS] = buf_data_q;
            consumer_read_ready_d = NUM_CONSUMERS'(1) << pick;
            state_d               = RELAY;
          end else
`endif
          begin
            mem_read_address_d = pick_addr;
            mem_read_valid_d   = 1'b1;
            state_d            = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (mem_read_ready) begin
          consumer_read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_d = NUM_CONSUMERS'(1) << grant_q;
          mem_read_valid_d      = 1'b0;
          state_d               = RELAY;
`ifdef FETCH_ARBITER_BYPASS_EN
          buf_valid_d = 1'b1;
          buf_addr_d  = mem_read_address_q;
          buf_data_d  = mem_read_data;
`endif
        end
      end
      RELAY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q               <= IDLE;
      grant_q               <= '0;
      last_grant_q          <= GW'(NUM_CONSUMERS - 1);
      mem_read_valid_q      <= 1'b0;
      mem_read_address_q    <= '0;
      consumer_read_ready_q <= '0;
      consumer_read_data_q  <= '0;
    end else begin
      state_q               <= state_d;
      grant_q               <= grant_d;
      last_grant_q          <= last_grant_d;
      mem_read_valid_q      <= mem_read_valid_d;
      mem_read_address_q    <= mem_read_address_d;
      consumer_read_ready_q <= consumer_read_ready_d;
      consumer_read_data_q  <= consumer_read_data_d;
    end
  end

`ifdef FETCH_ARBITER_BYPASS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign consumer_read_ready = consumer_read_ready_q;
  assign consumer_read_data  = consumer_read_data_q;
  assign mem_read_valid      = mem_read_valid_q;
  assign mem_read_address    = mem_read_address_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: directed scenarios plus randomized fetch traffic
// checked every cycle against a transaction-level reference model.
module tb_fetch_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    c_valid;
  logic [N*AW-1:0] c_addr;
  logic [N-1:0]    c_ready;
  logic [N*DW-1:0] c_data;
  logic            m_valid;
  logic [AW-1:0]   m_addr;
  logic            m_ready;
  logic [DW-1:0]   m_data;

  always #5 clk = ~clk;

  fetch_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (c_valid),
    .consumer_read_address (c_addr),
    .consumer_read_ready   (c_ready),
    .consumer_read_data    (c_data),
    .mem_read_valid        (m_valid),
    .mem_read_address      (m_addr),
    .mem_read_ready        (m_ready),
    .mem_read_data         (m_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: who owns the port, who is being answered, plus last winner.
  logic [N-1:0]  exp_ready;
  logic [DW-1:0] exp_data [N];
  logic          exp_mvalid;
  logic [AW-1:0] exp_maddr;
  int            owner, returning, last, win;
  logic          mb_valid;
  logic [AW-1:0] mb_addr;
  logic [DW-1:0] mb_data;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      exp_ready  = '0;
      for (int i = 0; i < N; i++) exp_data[i] = '0;
      exp_mvalid = 1'b0;
      exp_maddr  = '0;
      owner      = -1;
      returning  = -1;
      last       = N - 1;
      mb_valid   = 1'b0;
      mb_addr    = '0;
      mb_data    = '0;
    end else begin
      exp_ready = '0;
      if (returning >= 0) begin
        returning = -1;
      end else if (owner >= 0) begin
        if (m_ready) begin
          exp_data[owner]  = m_data;
          exp_ready[owner] = 1'b1;
          exp_mvalid       = 1'b0;
          mb_valid         = 1'b1;
          mb_addr          = exp_maddr;
          mb_data          = m_data;
          returning        = owner;
          owner            = -1;
        end
      end else begin
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && c_valid[(last + k) % N]) win = (last + k) % N;
        if (win >= 0) begin
          last = win;
`ifdef FETCH_ARBITER_BYPASS_EN
          if (mb_valid && c_addr[win*AW +: AW] == mb_addr) begin
            exp_data[win]  = mb_data;
            exp_ready[win] = 1'b1;
            returning      = win;
          end else
`endif
          begin
            owner      = win;
            exp_mvalid = 1'b1;
            exp_maddr  = c_addr[win*AW +: AW];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", 64'(c_ready), 64'(exp_ready));
      check("cyc_mvalid", 64'(m_valid), 64'(exp_mvalid));
      check("cyc_maddr", 64'(m_addr), 64'(exp_maddr));
      for (int i = 0; i < N; i++)
        check("cyc_data", 64'(c_data[i*DW +: DW]), 64'(exp_data[i]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_mvalid();
    for (int t = 0; t < 20; t++) begin
      if (m_valid) break;
      tick();
    end
    check("mvalid_wait", 64'(m_valid), 64'd1);
  endtask

  // Called on the negedge right after the grant edge; returns on the negedge
  // where the fetcher-side ready pulse is visible.
  task automatic mem_respond(input int k, input logic [DW-1:0] d);
    repeat (k - 1) tick();
    m_ready = 1'b1;
    m_data  = d;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [AW-1:0] got [5];
  int            ord [5];
  int            mcnt, mtarget, r;

  initial begin
    reset   = 1'b0;
    c_valid = '0;
    c_addr  = '0;
    m_ready = 1'b0;
    m_data  = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_ready", 64'(c_ready), 64'd0);
    check("rst_data", 64'(c_data), 64'd0);
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_maddr", 64'(m_addr), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) c_addr[i*AW +: AW] = 8'h40 + 8'(i);

    // single fetch from fetcher 1
    c_addr[1*AW +: AW] = 8'h12;
    c_valid[1] = 1'b1;
    tick();
    wait_mvalid();
    check("t1_addr", 64'(m_addr), 64'h12);
    mem_respond(3, 16'hABCD);
    check("t1_ready", 64'(c_ready), 64'b0010);
    check("t1_data1", 64'(c_data[1*DW +: DW]), 64'hABCD);
    check("t1_others", {16'h0, c_data[0 +: DW], c_data[2*DW +: DW], c_data[3*DW +: DW]}, 64'h0);
    c_valid[1] = 1'b0;
    tick();
    check("t1_ready_off", 64'(c_ready), 64'd0);
    c_addr[1*AW +: AW] = 8'h41;

    // all four requesting after reset
    do_reset();
    ord = '{0, 1, 2, 3, 0};
    c_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      tick();
      wait_mvalid();
      got[j] = m_addr;
      mem_respond(1, 16'h0100 + 16'(j));
      c_valid = c_valid & ~c_ready;
      tick();
      c_valid = 4'hF;
    end
    c_valid = '0;
    for (int j = 0; j < 5; j++) check("rr_order", 64'(got[j]), 64'(8'h40 + 8'(ord[j])));
    tick();

    // fairness: last grant 2, then 0 and 3 together
    do_reset();
    c_valid[2] = 1'b1;
    tick();
    wait_mvalid();
    mem_respond(2, 16'h2222);
    c_valid = '0;
    tick();
    c_valid = 4'b1001;
    tick();
    wait_mvalid();
    check("fair_first", 64'(m_addr), 64'h43);
    mem_respond(1, 16'h3333);
    check("fair_first_rdy", 64'(c_ready), 64'b1000);
    c_valid[3] = 1'b0;
    tick();
    tick();
    wait_mvalid();
    check("fair_second", 64'(m_addr), 64'h40);
    mem_respond(1, 16'h4444);
    c_valid = '0;
    tick();

    // reset taken during REQUEST
    c_valid[1] = 1'b1;
    tick();
    wait_mvalid();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    c_valid = 4'b0101;
    check("rstreq_mvalid", 64'(m_valid), 64'd0);
    check("rstreq_ready", 64'(c_ready), 64'd0);
    check("rstreq_data", 64'(c_data), 64'd0);
    tick();
    wait_mvalid();
    check("rstreq_regrant", 64'(m_addr), 64'h40);
    mem_respond(1, 16'h5555);
    check("rstreq_rdy0", 64'(c_ready), 64'b0001);
    c_valid = '0;
    tick();

    // spurious memory ready while idle
    m_ready = 1'b1;
    m_data  = 16'hDEAD;
    tick();
    m_ready = 1'b0;
    check("spur_ready", 64'(c_ready), 64'd0);
    check("spur_mvalid", 64'(m_valid), 64'd0);
    check("spur_data", 64'(c_data), 64'h5555);
    tick();
    check("spur_ready2", 64'(c_ready), 64'd0);
    check("spur_data2", 64'(c_data), 64'h5555);

    // same address fetched by two fetchers back to back
    c_addr[0*AW +: AW] = 8'h20;
    c_valid[0] = 1'b1;
    tick();
    wait_mvalid();
    mem_respond(2, 16'h1111);
    check("byp_first_rdy", 64'(c_ready), 64'b0001);
    c_valid[0] = 1'b0;
    c_addr[1*AW +: AW] = 8'h20;
    c_valid[1] = 1'b1;
    tick();
    tick();
`ifdef FETCH_ARBITER_BYPASS_EN
    check("byp_hit_ready", 64'(c_ready), 64'b0010);
    check("byp_hit_data", 64'(c_data[1*DW +: DW]), 64'h1111);
    check("byp_hit_mvalid", 64'(m_valid), 64'd0);
    c_valid[1] = 1'b0;
`else
    check("byp_miss_mvalid", 64'(m_valid), 64'd1);
    check("byp_miss_addr", 64'(m_addr), 64'h20);
    check("byp_miss_ready", 64'(c_ready), 64'd0);
    mem_respond(1, 16'h2121);
    check("byp_miss_rdy", 64'(c_ready), 64'b0010);
    check("byp_miss_data", 64'(c_data[1*DW +: DW]), 64'h2121);
    c_valid[1] = 1'b0;
`endif
    tick();

    // randomized traffic
    do_reset();
    c_valid = '0;
    mcnt    = 0;
    mtarget = $urandom_range(1, 4);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset   = 1'b0;
        mcnt    = 0;
        m_ready = 1'b0;
      end
      if (m_ready) begin
        m_ready = 1'b0;
      end else if (m_valid) begin
        mcnt++;
        if (mcnt >= mtarget) begin
          m_ready = 1'b1;
          m_data  = 16'($urandom);
          mcnt    = 0;
          mtarget = $urandom_range(1, 4);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        m_ready = 1'b1;
        m_data  = 16'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (c_valid[i] && c_ready[i]) begin
          c_valid[i] = 1'b0;
        end else if (!c_valid[i] && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 3);
          c_addr[i*AW +: AW] = (r < 3) ? 8'h20 + 8'(r) : 8'($urandom);
          c_valid[i] = 1'b1;
        end
      end
    end
    reset   = 1'b1;
    c_valid = '0;
    m_ready = 1'b0;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/fetch_arbiter.md
# fetch_arbiter

Shares the single program-memory read port between the per-core instruction fetchers. Each fetcher raises `valid` with an address and holds it until a one-cycle `ready` pulse returns its instruction. The arbiter grants one fetcher at a time in round-robin order, forwards that request to program memory, and returns the data to the granted fetcher only. It sits between the fetchers of all cores and the program-memory controller.

## Interface
- `NUM_CONSUMERS`, default 4: number of fetchers sharing the port; legal range 1..16.
- `ADDR_BITS`, default 8: program-memory address width.
- `DATA_BITS`, default 16: instruction width.

- `clk`  in  1  the only clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `consumer_read_valid`  in  NUM_CONSUMERS  request from fetcher i; bit i.
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  address from fetcher i; slice [i*ADDR_BITS +: ADDR_BITS].
- `consumer_read_ready`  out  NUM_CONSUMERS  one-cycle completion pulse to fetcher i.
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  instruction returned to fetcher i; slice [i*DATA_BITS +: DATA_BITS].
- `mem_read_valid`  out  1  request to program memory; held high until `mem_read_ready`.
- `mem_read_address`  out  ADDR_BITS  address of the request to program memory.
- `mem_read_ready`  in  1  program memory signals data valid; single-cycle pulse.
- `mem_read_data`  in  DATA_BITS  instruction from program memory, valid while `mem_read_ready` is high.

## Operation
- States:
  - IDLE (2'b00): no request is in flight.
  - REQUEST (2'b01): the memory request is outstanding.
  - RELAY (2'b10): the ready pulse is being returned to the fetcher.
- IDLE:
  - If any `consumer_read_valid` bit is set, grant the first set bit searching from `last_grant+1` upward, wrapping modulo NUM_CONSUMERS.
  - Register the grant index in `grant` and update `last_grant`.
  - Latch the granted address into `mem_read_address`, set `mem_read_valid`=1, and go to REQUEST.
- REQUEST:
  - On `mem_read_ready`=1, write `mem_read_data` into `consumer_read_data[grant]`.
  - In the same edge, set `consumer_read_ready[grant]`=1, clear `mem_read_valid`, and go to RELAY.
- RELAY: clear `consumer_read_ready` and go to IDLE. No new grant is made in this cycle.
- At most one `consumer_read_ready` bit is high in any cycle.
- `consumer_read_data` slices of non-granted fetchers are never written. Each slice holds its value until its fetcher's next completion.
- `mem_read_ready` is ignored outside REQUEST.
- If the granted fetcher drops `valid` during REQUEST (a protocol violation), the transfer still completes: the data is written and the ready pulse is issued.
- With NUM_CONSUMERS=1 the arbiter degenerates to a pass-through with the same state sequence.

## Timing
- Reset values, all outputs and state:
  - `consumer_read_ready`=0, `consumer_read_data`=0.
  - `mem_read_valid`=0, `mem_read_address`=0.
  - state=IDLE, `grant`=0, `last_grant`=NUM_CONSUMERS-1, so fetcher 0 wins first.
- Reset taken mid-REQUEST or mid-RELAY:
  - All outputs return to their reset values on that edge and the in-flight request is abandoned.
  - Program memory must tolerate `valid` dropping before `ready`.
- Latency from the edge E that samples `valid` in IDLE:
  - `mem_read_valid` is high from E.
  - If memory responds at edge E+k (k≥1), `consumer_read_ready` is high for the cycle after E+k.
  - The arbiter is back in IDLE at E+k+1.
  - Minimum fetcher-visible latency is 2 cycles; throughput is at most one fetch per 3 cycles.
- A fetcher clears `valid` on the edge it samples `ready`, so it is low in the following IDLE cycle and is not granted twice.

## Configuration
- `FETCH_ARBITER_BYPASS_EN` defined: adds a one-entry buffer holding `buf_valid`, `buf_addr` and `buf_data`.
  - Filled on every memory completion; cleared by reset.
  - In IDLE, if `buf_valid` is set and the granted address equals `buf_addr`:
    - write `buf_data` to the granted fetcher's data slice;
    - pulse its `consumer_read_ready` on the next cycle and go directly to RELAY;
    - `mem_read_valid` stays 0.
  - A hit therefore takes 1 cycle, and SIMT cores fetching the same PC are served without memory traffic.
  - Round-robin order is unchanged.
- Macro not defined: no buffer is present and every grant goes through REQUEST.

## Test plan
- Single fetch, 1 fetcher active: fetcher 1 requests address 0x12; memory returns 0xABCD with `ready` 3 cycles after `mem_read_valid`.
  -> `mem_read_address`=0x12.
  -> `consumer_read_ready[1]` pulses for exactly 1 cycle with `consumer_read_data[1]`=0xABCD.
  -> other slices unchanged.
- All 4 fetchers requesting continuously after reset -> grants in order 0,1,2,3,0.
- Fairness: last grant was 2, then fetchers 0 and 3 request together -> 3 is granted before 0.
- Reset held low for 1 cycle while in REQUEST -> the next cycle shows `mem_read_valid`=0, all ready bits 0, and the state in IDLE. A subsequent request from fetcher 0 is granted first.
- Spurious `mem_read_ready` while in IDLE -> no ready pulse and no data write.
- With `FETCH_ARBITER_BYPASS_EN`: fetcher 0 fetches 0x20 (memory returns 0x1111), then fetcher 1 fetches 0x20.
  -> the second fetch gets `consumer_read_data[1]`=0x1111 with no `mem_read_valid` assertion, 1 cycle after grant.
  -> without the macro, the second fetch issues a memory request.
